// File: rtl/small_fifo_drain_arb.sv
`default_nettype none
// ============================================================================
// Module   : small_fifo_drain_arb
// Purpose  : Round-robin drain scheduler for NUM_CH small flip-flop FIFOs
//            sharing one downstream byte stream. Issues single-cycle read
//            pulses, captures the word returned one cycle later and presents
//            it, tagged with its channel, on a valid/ready output. Up to
//            BURST_LEN words are drained per grant before rotating.
// Ports    : clk             - clock, rising edge
//            rst_n           - asynchronous active-low reset
//            enable          - block enable, low aborts activity
//            ch_mask         - per-channel grant enable
//            fifo_empty      - per-FIFO empty flags
//            fifo_read       - one-hot read pulse to the FIFOs
//            fifo_data       - FIFO outputs, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//            fifo_data_valid - per-FIFO data valid, one cycle after a read
//            out_data        - captured word
//            out_channel     - source channel of out_data
//            out_valid       - out_data/out_channel valid
//            out_ready       - downstream accept
//            rd_err          - pulse: expected data valid did not arrive
//            busy            - scheduler not idle in arbitration
// Revision : 1.0 - initial release
// ============================================================================
module small_fifo_drain_arb #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int CH_W       = 2,
    parameter int BURST_LEN  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic [NUM_CH-1:0]            fifo_empty,
    output logic [NUM_CH-1:0]            fifo_read,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
    input  logic [NUM_CH-1:0]            fifo_data_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_channel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         rd_err,
    output logic                         busy
);

    // Counter must be able to hold BURST_LEN itself on the final acceptance.
    localparam int c_CNT_W = $clog2(BURST_LEN + 1);

    localparam logic [1:0] c_ARB  = 2'd0;
    localparam logic [1:0] c_READ = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_HOLD = 2'd3;

    logic [1:0]            r_state,     w_state_nx;
    logic [CH_W-1:0]       r_rr_ptr,    w_rr_nx;
    logic [c_CNT_W-1:0]    r_burst_cnt, w_cnt_nx;
    logic [CH_W-1:0]       r_cur_ch,    w_cur_nx;
    logic [NUM_CH-1:0]     r_fifo_read, w_read_nx;
    logic [DATA_WIDTH-1:0] r_out_data,  w_data_nx;
    logic [CH_W-1:0]       r_out_chan,  w_chan_nx;
    logic                  r_out_valid, w_valid_nx;

    logic [NUM_CH-1:0]     w_cand;
    logic                  w_lo_v, w_hi_v, w_any;
    logic [CH_W-1:0]       w_lo_ch, w_hi_ch, w_grant_ch;
    logic [NUM_CH-1:0]     w_grant_oh, w_cur_oh;
    logic [DATA_WIDTH-1:0] w_cur_data;
    logic                  w_cur_dv, w_cur_empty, w_cur_mask;
    logic [CH_W-1:0]       w_next_ch;
    logic                  w_more;

    assign w_cand = ~fifo_empty & ch_mask;

    // Round-robin search: scanning downward leaves the lowest candidate at or
    // above rr_ptr in w_hi_ch, and the lowest candidate overall (the wrapped
    // choice) in w_lo_ch.
    always_comb begin : p_search
        w_lo_v  = 1'b0;
        w_hi_v  = 1'b0;
        w_lo_ch = '0;
        w_hi_ch = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_cand[j]) begin
                w_lo_v  = 1'b1;
                w_lo_ch = CH_W'(j);
                if (j >= int'(r_rr_ptr)) begin
                    w_hi_v  = 1'b1;
                    w_hi_ch = CH_W'(j);
                end
            end
        end
        w_any      = w_lo_v;
        w_grant_ch = w_hi_v ? w_hi_ch : w_lo_ch;
    end

    // Decode of the granted and current channel, and per-channel selection.
    always_comb begin : p_select
        w_grant_oh  = '0;
        w_cur_oh    = '0;
        w_cur_data  = '0;
        w_cur_dv    = 1'b0;
        w_cur_empty = 1'b1;
        w_cur_mask  = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            w_grant_oh[j] = (CH_W'(j) == w_grant_ch);
            w_cur_oh[j]   = (CH_W'(j) == r_cur_ch);
            if (CH_W'(j) == r_cur_ch) begin
                w_cur_data  = fifo_data[j*DATA_WIDTH +: DATA_WIDTH];
                w_cur_dv    = fifo_data_valid[j];
                w_cur_empty = fifo_empty[j];
                w_cur_mask  = ch_mask[j];
            end
        end
    end

    // Pointer wraps at NUM_CH-1, not at the natural width of CH_W.
    assign w_next_ch = (int'(r_cur_ch) == NUM_CH - 1) ? '0 : r_cur_ch + CH_W'(1);

    // Stay on the current channel only while burst budget remains and the
    // channel is still both non-empty and masked in.
    assign w_more = ((int'(r_burst_cnt) + 1) < BURST_LEN) && !w_cur_empty && w_cur_mask;

    always_comb begin : p_next
        w_state_nx = r_state;
        w_rr_nx    = r_rr_ptr;
        w_cnt_nx   = r_burst_cnt;
        w_cur_nx   = r_cur_ch;
        w_read_nx  = '0;
        w_data_nx  = r_out_data;
        w_chan_nx  = r_out_chan;
        w_valid_nx = r_out_valid;
        if (!enable) begin
            // Abort: any held word is dropped; rr_ptr and out_data persist.
            w_state_nx = c_ARB;
            w_valid_nx = 1'b0;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                c_ARB: begin
                    if (w_any) begin
                        w_cur_nx   = w_grant_ch;
                        w_cnt_nx   = '0;
                        w_read_nx  = w_grant_oh;
                        w_state_nx = c_READ;
                    end
                end
                c_READ: begin
                    w_state_nx = c_WAIT;
                end
                c_WAIT: begin
                    if (w_cur_dv) begin
                        w_data_nx  = w_cur_data;
                        w_chan_nx  = r_cur_ch;
                        w_valid_nx = 1'b1;
                        w_state_nx = c_HOLD;
                    end else begin
                        w_rr_nx    = w_next_ch;
                        w_state_nx = c_ARB;
                    end
                end
                c_HOLD: begin
                    if (r_out_valid && out_ready) begin
                        w_valid_nx = 1'b0;
                        w_cnt_nx   = r_burst_cnt + c_CNT_W'(1);
                        if (w_more) begin
                            w_read_nx  = w_cur_oh;
                            w_state_nx = c_READ;
                        end else begin
                            w_rr_nx    = w_next_ch;
                            w_state_nx = c_ARB;
                        end
                    end
                end
                default: begin
                    w_state_nx = c_ARB;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_regs
        if (!rst_n) begin
            r_state     <= c_ARB;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_cur_ch    <= '0;
            r_fifo_read <= '0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_rr_ptr    <= w_rr_nx;
            r_burst_cnt <= w_cnt_nx;
            r_cur_ch    <= w_cur_nx;
            r_fifo_read <= w_read_nx;
            r_out_data  <= w_data_nx;
            r_out_chan  <= w_chan_nx;
            r_out_valid <= w_valid_nx;
        end
    end

    assign fifo_read   = r_fifo_read;
    assign out_data    = r_out_data;
    assign out_channel = r_out_chan;
    assign out_valid   = r_out_valid;
    // Flagged during WAIT itself so it can never be seen in HOLD or ARB.
    assign rd_err      = (r_state == c_WAIT) && enable && !w_cur_dv;
    assign busy        = (r_state != c_ARB);

endmodule
`default_nettype wire

// File: tb/tb_small_fifo_drain_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_small_fifo_drain_arb
// Purpose  : Directed self-checking bench for small_fifo_drain_arb with four
//            modelled receive FIFOs (one-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_small_fifo_drain_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [3:0]  fifo_empty;
    logic [3:0]  fifo_read;
    logic [31:0] fifo_data = '0;
    logic [3:0]  fifo_data_valid = '0;
    logic [7:0]  out_data;
    logic [1:0]  out_channel;
    logic        out_valid;
    logic        out_ready;
    logic        rd_err;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    // FIFO model storage: wr_ptr owned by the stimulus, rd_ptr by the model.
    logic [7:0] mem [4][64];
    int         wr_ptr [4]     = '{default: 0};
    int         rd_ptr [4]     = '{default: 0};
    int         read_count [4] = '{default: 0};
    logic [3:0] suppress = '0;

    logic [7:0] got_d [16];
    logic [1:0] got_c [16];
    int         got_t [16];
    int         got_n;

    small_fifo_drain_arb #(
        .NUM_CH(4), .DATA_WIDTH(8), .CH_W(2), .BURST_LEN(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
        .fifo_empty(fifo_empty), .fifo_read(fifo_read), .fifo_data(fifo_data),
        .fifo_data_valid(fifo_data_valid), .out_data(out_data),
        .out_channel(out_channel), .out_valid(out_valid), .out_ready(out_ready),
        .rd_err(rd_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        fifo_empty = '1;
        for (int k = 0; k < 4; k++) fifo_empty[k] = (wr_ptr[k] == rd_ptr[k]);
    end

    always @(posedge clk) begin
        fifo_data_valid <= '0;
        for (int k = 0; k < 4; k++) begin
            if (fifo_read[k]) begin
                read_count[k] <= read_count[k] + 1;
                if (rd_ptr[k] != wr_ptr[k]) begin
                    fifo_data[k*8 +: 8] <= mem[k][rd_ptr[k][5:0]];
                    rd_ptr[k] <= rd_ptr[k] + 1;
                    if (!suppress[k]) fifo_data_valid[k] <= 1'b1;
                end
            end
        end
    end

    task automatic push(input int ch, input logic [7:0] d);
        mem[ch[1:0]][wr_ptr[ch[1:0]][5:0]] = d;
        wr_ptr[ch[1:0]] = wr_ptr[ch[1:0]] + 1;
    endtask

    function automatic int total_reads();
        return read_count[0] + read_count[1] + read_count[2] + read_count[3];
    endfunction

    task automatic collect(input int ncyc);
        got_n = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (out_valid && out_ready && got_n < 16) begin
                got_d[got_n] = out_data;
                got_c[got_n] = out_channel;
                got_t[got_n] = c;
                got_n++;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; ch_mask = 4'hF; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (fifo_read !== 4'b0) begin miscompares++; $display("FAIL reset_fifo_read: got %b want 0000", fifo_read); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        vectors++; if (out_channel !== 2'd0) begin miscompares++; $display("FAIL reset_out_channel: got %0d want 0", out_channel); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_word();
        out_ready = 1'b0;
        push(2, 8'hA5);
        @(negedge clk);
        vectors++; if (fifo_read !== 4'b0100) begin miscompares++; $display("FAIL single_read: got %b want 0100", fifo_read); end
        @(negedge clk);
        vectors++; if (fifo_read !== 4'b0000 || out_valid !== 1'b0) begin miscompares++; $display("FAIL single_wait: read %b valid %b want 0000/0", fifo_read, out_valid); end
        @(negedge clk);
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_channel !== 2'd2) begin miscompares++; $display("FAIL single_out: valid %b data %h ch %0d want 1/a5/2", out_valid, out_data, out_channel); end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL single_accept: valid %b busy %b want 0/0", out_valid, busy); end
        vectors++; if (dut.r_rr_ptr !== 2'd3) begin miscompares++; $display("FAIL single_rr_ptr: got %0d want 3", dut.r_rr_ptr); end
    endtask

    task automatic test_burst_limit();
        int gaps [5] = '{3, 3, 3, 4, 3};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(0, 8'(16 + i));
        collect(30);
        vectors++; if (got_n !== 6) begin miscompares++; $display("FAIL burst_count: got %0d words want 6", got_n); end
        for (int i = 0; i < got_n && i < 6; i++) begin
            vectors++;
            if (got_d[i] !== 8'(16 + i) || got_c[i] !== 2'd0) begin miscompares++; $display("FAIL burst_word%0d: data %h ch %0d want %h/0", i, got_d[i], got_c[i], 8'(16 + i)); end
        end
        for (int i = 0; i + 1 < got_n && i < 5; i++) begin
            vectors++;
            if (got_t[i+1] - got_t[i] !== gaps[i]) begin miscompares++; $display("FAIL burst_gap%0d: got %0d cycles want %0d", i, got_t[i+1] - got_t[i], gaps[i]); end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_c [3] = '{2'd0, 2'd1, 2'd3};
        int r2;
        do_reset();
        out_ready = 1'b1; ch_mask = 4'hF;
        for (int k = 0; k < 4; k++) push(k, 8'(32 + k));
        collect(40);
        vectors++; if (got_n !== 4) begin miscompares++; $display("FAIL rr_count: got %0d want 4", got_n); end
        for (int i = 0; i < got_n && i < 4; i++) begin
            vectors++;
            if (got_c[i] !== 2'(i) || got_d[i] !== 8'(32 + i)) begin miscompares++; $display("FAIL rr_order%0d: ch %0d data %h want %0d/%h", i, got_c[i], got_d[i], i, 8'(32 + i)); end
        end
        ch_mask = 4'b1011;
        r2 = read_count[2];
        for (int k = 0; k < 4; k++) push(k, 8'(48 + k));
        collect(40);
        vectors++; if (got_n !== 3) begin miscompares++; $display("FAIL rr_mask_count: got %0d want 3", got_n); end
        for (int i = 0; i < got_n && i < 3; i++) begin
            vectors++;
            if (got_c[i] !== exp_c[i] || got_d[i] !== 8'(48 + int'(exp_c[i]))) begin miscompares++; $display("FAIL rr_mask_order%0d: ch %0d data %h want %0d", i, got_c[i], got_d[i], exp_c[i]); end
        end
        vectors++; if (read_count[2] !== r2) begin miscompares++; $display("FAIL rr_masked_read: ch2 reads %0d want %0d", read_count[2], r2); end
        wr_ptr[2] = rd_ptr[2];
        ch_mask = 4'hF;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n = 0;
        int reads;
        out_ready = 1'b0;
        push(1, 8'h5C);
        push(3, 8'h3C);
        while (out_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h5C || out_channel !== 2'd1) begin miscompares++; $display("FAIL bp_first: valid %b data %h ch %0d want 1/5c/1", out_valid, out_data, out_channel); end
        reads = total_reads();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'h5C || out_channel !== 2'd1 || fifo_read !== 4'b0) begin miscompares++; $display("FAIL bp_hold%0d: valid %b data %h ch %0d read %b", c, out_valid, out_data, out_channel, fifo_read); end
        end
        vectors++; if (total_reads() !== reads) begin miscompares++; $display("FAIL bp_no_reads: got %0d want %0d", total_reads(), reads); end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_accept: valid %b want 0", out_valid); end
        collect(10);
        vectors++; if (got_n !== 1 || got_d[0] !== 8'h3C || got_c[0] !== 2'd3) begin miscompares++; $display("FAIL bp_next: n %0d data %h ch %0d want 1/3c/3", got_n, got_d[0], got_c[0]); end
    endtask

    task automatic test_missing_valid();
        out_ready = 1'b1;
        suppress = 4'b0010;
        push(1, 8'h77);
        push(2, 8'h88);
        @(negedge clk);
        vectors++; if (fifo_read !== 4'b0010) begin miscompares++; $display("FAIL mv_read: got %b want 0010", fifo_read); end
        @(negedge clk);
        vectors++; if (rd_err !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL mv_err: rd_err %b busy %b want 1/1", rd_err, busy); end
        @(negedge clk);
        vectors++; if (rd_err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mv_arb: rd_err %b busy %b valid %b want 0/0/0", rd_err, busy, out_valid); end
        suppress = 4'b0000;
        @(negedge clk);
        vectors++; if (fifo_read !== 4'b0100) begin miscompares++; $display("FAIL mv_next_grant: got %b want 0100", fifo_read); end
        collect(6);
        vectors++; if (got_n !== 1 || got_d[0] !== 8'h88) begin miscompares++; $display("FAIL mv_word: n %0d data %h want 1/88", got_n, got_d[0]); end
    endtask

    task automatic test_abort_and_reset();
        int n = 0;
        int reads;
        out_ready = 1'b0;
        push(0, 8'h42);
        while (out_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        vectors++; if (out_valid !== 1'b1 || out_data !== 8'h42) begin miscompares++; $display("FAIL ab_hold: valid %b data %h want 1/42", out_valid, out_data); end
        enable = 1'b0;
        push(0, 8'h43);
        reads = total_reads();
        @(negedge clk);
        vectors++; if (out_valid !== 1'b0 || fifo_read !== 4'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL ab_drop: valid %b read %b busy %b want 0/0000/0", out_valid, fifo_read, busy); end
        repeat (4) @(negedge clk);
        vectors++; if (total_reads() !== reads || out_data !== 8'h42) begin miscompares++; $display("FAIL ab_idle: reads %0d data %h want %0d/42", total_reads(), out_data, reads); end
        enable = 1'b1;
        @(negedge clk);
        vectors++; if (fifo_read !== 4'b0001) begin miscompares++; $display("FAIL ab_regrant: got %b want 0001", fifo_read); end
        #1 rst_n = 1'b0;
        #1;
        vectors++; if (fifo_read !== 4'b0) begin miscompares++; $display("FAIL async_read: got %b want 0000", fifo_read); end
        vectors++; if (out_data !== 8'h00 || out_channel !== 2'd0 || out_valid !== 1'b0 || busy !== 1'b0 || rd_err !== 1'b0) begin miscompares++; $display("FAIL async_outs: data %h ch %0d valid %b busy %b err %b want all 0", out_data, out_channel, out_valid, busy, rd_err); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_burst_limit();
        test_round_robin();
        test_backpressure();
        test_missing_valid();
        test_abort_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
